midi_uart_fifo: RTL

Parametrised full-duplex MIDI UART for the synth controller, replacing the derived-clock receiver/transmitter with a single-clock, oversampled design. All timing comes from one `reg_clk` via clock-enable ticks. The block has FIFOs in both directions and a glitch-rejecting receiver with framing-error detection. Each received byte is tagged with the current running status and its data-byte index before it reaches the MIDI decoder.

---
 rtl/midi_uart_pkg.sv | 16 +
 rtl/midi_sync_fifo.sv | 46 ++++
 rtl/midi_uart_fifo.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/midi_uart_pkg.sv
// midi_uart_pkg: shared FSM state types, MIDI byte classes and tagging helpers.
package midi_uart_pkg;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    localparam logic [7:0] MIDI_STATUS_MIN = 8'h80;
    localparam logic [7:0] MIDI_EOX        = 8'hF7;
    localparam logic [7:0] MIDI_RT_MIN     = 8'hF8;

    // True for bytes that replace the running status (channel, system common, SysEx start).
    function automatic logic is_running_status(input logic [7:0] b);
        return (b >= MIDI_STATUS_MIN) && (b < MIDI_EOX);
    endfunction

endpackage

// File: rtl/midi_sync_fifo.sv
// midi_sync_fifo: single-clock show-ahead FIFO; a push into a full FIFO succeeds
// only when a pop happens in the same cycle.
module midi_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because empty gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/midi_uart_fifo.sv
// midi_uart_fifo: oversampled single-clock MIDI UART with RX/TX FIFOs,
// glitch rejection, framing-error detection and running-status tagging.
module midi_uart_fifo
    import midi_uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 31250,
    parameter int OVERSAMPLE = 16,
    parameter int RX_DEPTH   = 16,
    parameter int TX_DEPTH   = 16
) (
    input  logic       reg_clk,
    input  logic       reset_reg_N,
    input  logic       midi_rxd,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic [7:0] rx_status,
    output logic [7:0] rx_byte_nr,
    output logic       rx_overrun,
    output logic       rx_frame_err,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       midi_txd,
    output logic       tx_busy
);
    localparam int TICK_HZ = BAUD * OVERSAMPLE;
    localparam int DIV     = (CLK_HZ + TICK_HZ / 2) / TICK_HZ;
    localparam int PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW      = $clog2(OVERSAMPLE);
    localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

    if (DIV < 2) begin : g_div_check
        $error("midi_uart_fifo: clock divider below 2");
    end

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // ---------------- RX ----------------
    rx_state_t     rx_state, rx_next;
    logic          sync1, sync2, rxd_prev, rx_fall, rx_mid;
    logic [PW-1:0] rx_pre;
    logic [TW-1:0] rx_tick;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shreg, rx_byte_p1;
    logic          rx_restart, rx_shift, rx_push_stb, rx_ferr_stb, vld_p1;
    logic [7:0]    tag_status, tag_nr, status_nx, nr_nx;
    logic [23:0]   rx_head;
    logic          rx_full, rx_empty, rx_pop;

    assign rx_fall = rxd_prev & ~sync2;
    assign rx_mid  = (rx_pre == PRE_LAST) && (rx_tick == TICK_MID);
    assign rx_pop  = rx_ready && !rx_empty;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection; idles high.
    always_ff @(posedge reg_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            sync1    <= midi_rxd;
            sync2    <= sync1;
            rxd_prev <= sync2;
        end
    end

    // RX state register.
    always_ff @(posedge reg_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) rx_state <= RX_IDLE;
        else              rx_state <= rx_next;
    end

    // RX next state: every decision is taken at the mid-bit sample point.
    always_comb begin
        rx_next     = rx_state;
        rx_restart  = 1'b0;
        rx_shift    = 1'b0;
        rx_push_stb = 1'b0;
        rx_ferr_stb = 1'b0;
        unique case (rx_state)
            RX_IDLE:  if (rx_fall) begin
                          rx_next    = RX_START;
                          rx_restart = 1'b1;
                      end
            RX_START: if (rx_mid) rx_next = sync2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_mid) begin
                          rx_shift = 1'b1;
                          if (rx_bit == 3'd7) rx_next = RX_STOP;
                      end
            RX_STOP:  if (rx_mid) begin
                          rx_next     = RX_IDLE;
                          rx_push_stb = sync2;
                          rx_ferr_stb = ~sync2;
                      end
            default:  rx_next = RX_IDLE;
        endcase
    end

    // RX prescaler, tick and bit counters; realigned to each start edge.
    always_ff @(posedge reg_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            rx_pre  <= '0;
            rx_tick <= '0;
            rx_bit  <= '0;
        end else if (rx_restart) begin
            rx_pre  <= '0;
            rx_tick <= '0;
            rx_bit  <= '0;
        end else begin
            if (rx_pre == PRE_LAST) begin
                rx_pre  <= '0;
                rx_tick <= (rx_tick == TICK_LAST) ? '0 : rx_tick + 1'b1;
            end else begin
                rx_pre <= rx_pre + 1'b1;
            end
            if (rx_shift) rx_bit <= rx_bit + 1'b1;
        end
    end

    // RX data shift (LSB first) and capture of the completed byte.
    always_ff @(posedge reg_clk) begin
        if (rx_shift)    rx_shreg   <= {sync2, rx_shreg[7:1]};
        if (rx_push_stb) rx_byte_p1 <= rx_shreg;
    end

    // Tag rules: new status resets the index, realtime leaves everything alone.
    always_comb begin
        status_nx = tag_status;
        nr_nx     = tag_nr;
        if (is_running_status(rx_byte_p1)) begin
            status_nx = rx_byte_p1;
            nr_nx     = 8'd0;
        end else if (rx_byte_p1 < MIDI_RT_MIN) begin
            nr_nx = sat_inc(tag_nr);
        end
    end

    // Push strobe stage, tag state and the one-cycle error pulses.
    always_ff @(posedge reg_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            vld_p1       <= 1'b0;
            tag_status   <= 8'd0;
            tag_nr       <= 8'd0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            vld_p1       <= rx_push_stb;
            rx_frame_err <= rx_ferr_stb;
            rx_overrun   <= vld_p1 && rx_full && !rx_pop;
            if (vld_p1) begin
                tag_status <= status_nx;
                tag_nr     <= nr_nx;
            end
        end
    end

    midi_sync_fifo #(.WIDTH(24), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (reg_clk),
        .rst_n     (reset_reg_N),
        .push      (vld_p1),
        .push_data ({status_nx, nr_nx, rx_byte_p1}),
        .pop       (rx_pop),
        .pop_data  (rx_head),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    assign rx_valid   = !rx_empty;
    assign rx_status  = rx_valid ? rx_head[23:16] : 8'd0;
    assign rx_byte_nr = rx_valid ? rx_head[15:8]  : 8'd0;
    assign rx_data    = rx_valid ? rx_head[7:0]   : 8'd0;

    // ---------------- TX ----------------
    tx_state_t     tx_state, tx_next;
    logic [PW-1:0] tx_pre;
    logic [TW-1:0] tx_tick;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shreg, tx_head;
    logic          tx_ps_tick, tx_bit_end, tx_pop, tx_full, tx_empty;

    assign tx_ps_tick = (tx_pre == PRE_LAST);
    assign tx_bit_end = tx_ps_tick && (tx_tick == TICK_LAST);
    assign tx_ready   = !tx_full;
    assign tx_busy    = (tx_state != TX_IDLE) || !tx_empty;

    midi_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (reg_clk),
        .rst_n     (reset_reg_N),
        .push      (tx_valid && tx_ready),
        .push_data (tx_data),
        .pop       (tx_pop),
        .pop_data  (tx_head),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    // TX state register.
    always_ff @(posedge reg_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) tx_state <= TX_IDLE;
        else              tx_state <= tx_next;
    end

    // TX next state: a pop starts a frame; STOP chains straight into the next one.
    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        unique case (tx_state)
            TX_IDLE:  if (tx_ps_tick && !tx_empty) begin
                          tx_next = TX_START;
                          tx_pop  = 1'b1;
                      end
            TX_START: if (tx_bit_end) tx_next = TX_DATA;
            TX_DATA:  if (tx_bit_end && tx_bit == 3'd7) tx_next = TX_STOP;
            TX_STOP:  if (tx_bit_end) begin
                          if (!tx_empty) begin
                              tx_next = TX_START;
                              tx_pop  = 1'b1;
                          end else begin
                              tx_next = TX_IDLE;
                          end
                      end
            default:  tx_next = TX_IDLE;
        endcase
    end

    // TX prescaler, bit timing and serial output register.
    always_ff @(posedge reg_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            tx_pre   <= '0;
            tx_tick  <= '0;
            tx_bit   <= '0;
            midi_txd <= 1'b1;
        end else begin
            tx_pre <= tx_ps_tick ? '0 : tx_pre + 1'b1;
            if (tx_pop)          tx_tick <= '0;
            else if (tx_ps_tick) tx_tick <= (tx_tick == TICK_LAST) ? '0 : tx_tick + 1'b1;
            if (tx_pop) begin
                midi_txd <= 1'b0;
            end else if (tx_bit_end) begin
                case (tx_state)
                    TX_START: begin
                        midi_txd <= tx_shreg[0];
                        tx_bit   <= '0;
                    end
                    TX_DATA: begin
                        midi_txd <= (tx_bit == 3'd7) ? 1'b1 : tx_shreg[0];
                        tx_bit   <= tx_bit + 1'b1;
                    end
                    default: midi_txd <= 1'b1;
                endcase
            end
        end
    end

    // TX shift register: loaded on pop, shifted as each data bit goes out.
    always_ff @(posedge reg_clk) begin
        if (tx_pop)
            tx_shreg <= tx_head;
        else if (tx_bit_end && (tx_state == TX_START || tx_state == TX_DATA))
            tx_shreg <= {1'b0, tx_shreg[7:1]};
    end

endmodule
